// File: rtl/fetch_pkg.sv
// ============================================================================
//  Module   : fetch_pkg
//  Brief    : Shared types and constants for the instruction fetch controller.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package fetch_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    // One-hot redirect source encoding, ordered {trap, branch, jump}
    localparam logic [2:0] c_sel_none = 3'b000;
    localparam logic [2:0] c_sel_trap = 3'b100;
    localparam logic [2:0] c_sel_br   = 3'b010;
    localparam logic [2:0] c_sel_jmp  = 3'b001;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
//  Module   : fetch_queue
//  Brief    : Circular FIFO of fetched {pc, instr} entries with flush.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fetch_queue
    import fetch_pkg::*;
#(
    parameter int QUEUE_DEPTH = 2
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_push,
    input  fetch_entry_t                   i_entry,
    input  logic                           i_pop,
    input  logic                           i_flush,
    output logic [$clog2(QUEUE_DEPTH):0]   o_count,
    output fetch_entry_t                   o_head
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] c_depth = CW'(QUEUE_DEPTH);

    fetch_entry_t    r_mem [QUEUE_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    // Guard against misuse even though the controller never over/underflows
    assign w_do_push = i_push && (r_count != c_depth);
    assign w_do_pop  = i_pop  && (r_count != '0);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the count alone
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
//  Module   : fetch_ctrl
//  Brief    : Fetch PC owner, redirect arbiter and single-outstanding imem
//             request sequencer feeding decode through a small queue.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'd0,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_trap_valid,
    input  logic [31:0] i_trap_pc,
    input  logic        i_br_valid,
    input  logic [31:0] i_br_pc,
    input  logic        i_jmp_valid,
    input  logic [31:0] i_jmp_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_if_valid,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_if_instr,
    input  logic        i_id_ready,
    output logic [2:0]  o_redirect_sel
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW-1:0] c_depth = CW'(QUEUE_DEPTH);

    fetch_state_e   r_state;
    fetch_state_e   w_state_nxt;
    logic [31:0]    r_fetch_pc;
    logic [31:0]    r_out_pc;
    logic [31:0]    w_redir_pc;
    logic [2:0]     w_redir_sel;
    logic           w_redir;
    logic           w_req;
    logic           w_push;
    logic           w_pop;
    logic           w_if_valid;
    logic [CW-1:0]  w_count;
    fetch_entry_t   w_head;
    fetch_entry_t   w_push_entry;

    // Fixed-priority redirect arbiter: trap > branch > jump
    always_comb begin
        w_redir_sel = c_sel_none;
        w_redir_pc  = r_fetch_pc;
        if (!i_rst) begin
            if (i_trap_valid) begin
                w_redir_sel = c_sel_trap;
                w_redir_pc  = i_trap_pc;
            end else if (i_br_valid) begin
                w_redir_sel = c_sel_br;
                w_redir_pc  = i_br_pc;
            end else if (i_jmp_valid) begin
                w_redir_sel = c_sel_jmp;
                w_redir_pc  = i_jmp_pc;
            end
        end
    end

    assign w_redir = |w_redir_sel;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A redirect in WAIT drops the in-flight response unless it lands now
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_REQ: begin
                if (w_req && i_imem_gnt) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_imem_rvalid) begin
                    w_state_nxt = ST_REQ;
                end else if (w_redir) begin
                    w_state_nxt = ST_DROP;
                end
            end
            ST_DROP: begin
                if (i_imem_rvalid) begin
                    w_state_nxt = ST_REQ;
                end
            end
            default: w_state_nxt = ST_REQ;
        endcase
    end

    always_comb begin
        w_req  = 1'b0;
        w_push = 1'b0;
        case (r_state)
            ST_REQ:  w_req  = !i_rst && (w_count < c_depth) && !w_redir;
            ST_WAIT: w_push = !i_rst && i_imem_rvalid && !w_redir;
            default: begin
                w_req  = 1'b0;
                w_push = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_pc <= RESET_PC;
            r_out_pc   <= '0;
        end else if (w_redir) begin
            r_fetch_pc <= w_redir_pc;
        end else if (w_req && i_imem_gnt) begin
            r_out_pc   <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + 32'd1;
        end
    end

    assign w_push_entry = '{pc: r_out_pc, instr: i_imem_rdata};
    assign w_if_valid   = !i_rst && (w_count != '0) && !w_redir;
    assign w_pop        = w_if_valid && i_id_ready;

    fetch_queue #(
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (w_redir),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign o_imem_req     = w_req;
    assign o_imem_addr    = i_rst ? 32'd0 : r_fetch_pc;
    assign o_if_valid     = w_if_valid;
    assign o_if_pc        = w_if_valid ? w_head.pc    : 32'd0;
    assign o_if_instr     = w_if_valid ? w_head.instr : 32'd0;
    assign o_redirect_sel = w_redir_sel;

    // A response with nothing outstanding means the memory broke protocol
    a_no_spurious_rvalid: assert property (
        @(posedge i_clk) disable iff (i_rst) !(i_imem_rvalid && (r_state == ST_REQ))
    );

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
//  Module   : tb_fetch_ctrl
//  Brief    : Scoreboard bench for fetch_ctrl with a latency-randomised imem.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC    = 32'd0;
    localparam int          QUEUE_DEPTH = 2;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_trap_valid, i_br_valid, i_jmp_valid;
    logic [31:0] i_trap_pc, i_br_pc, i_jmp_pc;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt, i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_if_valid;
    logic [31:0] o_if_pc, o_if_instr;
    logic        i_id_ready;
    logic [2:0]  o_redirect_sel;

    fetch_ctrl #(
        .RESET_PC    (RESET_PC),
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_trap_valid   (i_trap_valid),
        .i_trap_pc      (i_trap_pc),
        .i_br_valid     (i_br_valid),
        .i_br_pc        (i_br_pc),
        .i_jmp_valid    (i_jmp_valid),
        .i_jmp_pc       (i_jmp_pc),
        .o_imem_req     (o_imem_req),
        .o_imem_addr    (o_imem_addr),
        .i_imem_gnt     (i_imem_gnt),
        .i_imem_rvalid  (i_imem_rvalid),
        .i_imem_rdata   (i_imem_rdata),
        .o_if_valid     (o_if_valid),
        .o_if_pc        (o_if_pc),
        .o_if_instr     (o_if_instr),
        .i_id_ready     (i_id_ready),
        .o_redirect_sel (o_redirect_sel)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory contents as a pure function of the word address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected stream of PCs delivered to decode: consecutive from the last target
    logic [31:0] exp_q[$];
    task automatic refill(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 512; i++) exp_q.push_back(start + 32'(i));
    endtask

    // imem responder: grant with probability gnt_pct, answer after lat cycles
    int          gnt_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          mem_pend = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = '0;
    initial begin : p_mem
        bit          granted;
        logic [31:0] gaddr;
        i_imem_gnt = 1'b1; i_imem_rvalid = 1'b0; i_imem_rdata = '0;
        forever begin
            @(negedge clk);
            granted = o_imem_req && i_imem_gnt;
            gaddr   = o_imem_addr;
            @(posedge clk); #1;
            if (granted) begin
                mem_pend = 1'b1;
                mem_addr = gaddr;
                mem_cnt  = int'($urandom_range(lat_max, lat_min));
            end
            i_imem_rvalid = 1'b0;
            i_imem_rdata  = $urandom;
            if (mem_pend) begin
                if (mem_cnt <= 1) begin
                    i_imem_rvalid = 1'b1;
                    i_imem_rdata  = mem_word(mem_addr);
                    mem_pend      = 1'b0;
                end else begin
                    mem_cnt--;
                end
            end
            i_imem_gnt = (int'($urandom_range(99, 0)) < gnt_pct);
        end
    end

    // Monitor: every accepted instruction is popped against the scoreboard
    int n_pops = 0;
    int pop_cyc[$];
    initial begin : p_mon
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (o_if_valid && i_id_ready) begin
                n_pops++;
                pop_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_pop: got pc %0h, scoreboard empty", o_if_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("if_pc", o_if_pc, e);
                    check("if_instr", o_if_instr, mem_word(e));
                end
            end
        end
    end

    // All stimulus tasks start and end 1ns after a rising edge
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset(input int n);
        i_rst = 1'b1;
        repeat (n) begin
            @(negedge clk);
            check("rst_ctrl", {o_imem_req, o_if_valid, o_redirect_sel}, 0);
            check("rst_addr", o_imem_addr, 0);
            check("rst_if", {o_if_pc, o_if_instr}, 0);
            @(posedge clk); #1;
        end
        refill(RESET_PC);
        i_rst = 1'b0;
    endtask

    task automatic post_reset_check();
        #2;
        check("post_rst_addr", o_imem_addr, RESET_PC);
        check("post_rst_req", o_imem_req, 1);
        check("post_rst_valid", o_if_valid, 0);
        check("post_rst_sel", o_redirect_sel, 0);
    endtask

    task automatic wait_grant(output logic [31:0] addr, output int gcyc, input string name);
        bit found;
        found = 1'b0; addr = '0; gcyc = 0;
        for (int k = 0; k < 80 && !found; k++) begin
            @(negedge clk);
            if (o_imem_req && i_imem_gnt) begin
                found = 1'b1; addr = o_imem_addr; gcyc = cyc;
            end
            @(posedge clk); #1;
        end
        if (!found) begin
            n_checks++; n_fail++;
            $display("FAIL %s: no granted request within 80 cycles", name);
        end
    endtask

    task automatic wait_pops(input int n, input string name);
        for (int k = 0; k < 80 && n_pops < n; k++) idle(1);
        if (n_pops < n) begin
            n_checks++; n_fail++;
            $display("FAIL %s: %0d instructions accepted, wanted %0d", name, n_pops, n);
        end
    endtask

    task automatic redirect(input bit t, input bit b, input bit j,
                            input logic [31:0] tp, input logic [31:0] bp, input logic [31:0] jp);
        logic [2:0]  exp_sel;
        logic [31:0] tgt;
        i_trap_valid = t; i_trap_pc = tp;
        i_br_valid   = b; i_br_pc   = bp;
        i_jmp_valid  = j; i_jmp_pc  = jp;
        if (t)      begin exp_sel = 3'b100; tgt = tp; end
        else if (b) begin exp_sel = 3'b010; tgt = bp; end
        else if (j) begin exp_sel = 3'b001; tgt = jp; end
        else        begin exp_sel = 3'b000; tgt = '0; end
        @(negedge clk);
        check("redirect_sel", o_redirect_sel, exp_sel);
        if (exp_sel != 3'b000) begin
            check("valid_in_redirect", o_if_valid, 0);
            check("req_in_redirect", o_imem_req, 0);
            refill(tgt);
        end
        @(posedge clk); #1;
        i_trap_valid = 1'b0; i_br_valid = 1'b0; i_jmp_valid = 1'b0;
    endtask

    initial begin : p_stim
        logic [31:0] a;
        int          g1, g2, base;
        int          since;
        bit          t, b, j;
        i_rst = 1'b1;
        i_trap_valid = 1'b0; i_br_valid = 1'b0; i_jmp_valid = 1'b0;
        i_trap_pc = '0; i_br_pc = '0; i_jmp_pc = '0;
        i_id_ready = 1'b1;
        @(posedge clk); #1;

        // Sequential fetch at full grant rate, one-cycle latency
        do_reset(3);
        pop_cyc.delete(); n_pops = 0;
        post_reset_check();
        for (int k = 0; k < 4; k++) begin
            wait_grant(a, g1, "seq_grant");
            check("seq_addr", a, RESET_PC + 32'(k));
        end
        wait_pops(4, "seq_pops");
        if (pop_cyc.size() >= 4) begin
            for (int k = 1; k < 4; k++) check("throughput_gap", pop_cyc[k] - pop_cyc[k-1], 2);
        end

        // Decode stalled: queue fills and requests stop
        i_id_ready = 1'b0;
        do_reset(3);
        idle(12);
        @(negedge clk);
        check("stall_req", o_imem_req, 0);
        check("stall_valid", o_if_valid, 1);
        check("stall_head_pc", o_if_pc, RESET_PC);
        check("stall_head_instr", o_if_instr, mem_word(RESET_PC));
        @(posedge clk); #1;
        i_id_ready = 1'b1;
        wait_grant(a, g1, "resume_grant");
        check("resume_addr", a, RESET_PC + 32'd2);
        idle(6);

        // Branch while a slow response is outstanding
        lat_min = 4; lat_max = 4;
        wait_grant(a, g1, "drop_grant0");
        redirect(1'b0, 1'b1, 1'b0, '0, 32'h40, '0);
        wait_grant(a, g2, "drop_grant1");
        check("drop_addr", a, 32'h40);
        check("drop_gap", g2 - g1, 5);
        lat_min = 1; lat_max = 1;
        idle(10);

        // Priority among simultaneous redirects
        redirect(1'b1, 1'b1, 1'b1, 32'h100, 32'h200, 32'h300);
        wait_grant(a, g1, "prio_grant0");
        check("prio_trap_addr", a, 32'h100);
        idle(3);
        redirect(1'b0, 1'b1, 1'b1, 32'h100, 32'h200, 32'h300);
        wait_grant(a, g1, "prio_grant1");
        check("prio_br_addr", a, 32'h200);
        idle(3);

        // PC wraps modulo 2^32
        redirect(1'b0, 1'b0, 1'b1, '0, '0, 32'hFFFF_FFFF);
        wait_grant(a, g1, "wrap_grant0");
        check("wrap_addr0", a, 32'hFFFF_FFFF);
        wait_grant(a, g1, "wrap_grant1");
        check("wrap_addr1", a, 32'h0);
        idle(6);

        // Reset while waiting; the response lands during reset
        lat_min = 2; lat_max = 2;
        wait_grant(a, g1, "rstw_grant");
        do_reset(4);
        post_reset_check();
        wait_grant(a, g1, "rstw_first");
        check("rstw_addr", a, RESET_PC);
        idle(6);

        // Randomised traffic
        gnt_pct = 70; lat_min = 1; lat_max = 4;
        since = 0;
        base = n_pops;
        for (int c = 0; c < 2000; c++) begin
            i_id_ready = (int'($urandom_range(99, 0)) < 70);
            if (int'($urandom_range(99, 0)) < 4 || since > 250) begin
                t = 1'($urandom_range(1, 0));
                b = 1'($urandom_range(1, 0));
                j = 1'($urandom_range(1, 0)) || (since > 250);
                redirect(t, b, j, $urandom, $urandom, 32'hFFFF_FFFF - 32'($urandom_range(3, 0)));
                since = 0;
            end else begin
                idle(1);
                since++;
            end
        end
        i_id_ready = 1'b1;
        idle(30);
        check("random_progress", (n_pops - base) > 200, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : p_watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
